// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - update handshake and digit-selector bus for seg_scan_ctrl
interface seg_scan_ctrl_if;
    // host update request and its acknowledge
    logic        upd;
    logic [31:0] dig_in;
    logic        upd_ack;
    // digit selector loop: controller drives num/dig, selector returns code
    logic [2:0]  num;
    logic [31:0] dig;
    logic [3:0]  code;

    // environment side: host plus external digit selector
    modport master (
        output upd,
        output dig_in,
        output code,
        input  upd_ack,
        input  num,
        input  dig
    );

    // controller side
    modport slave (
        input  upd,
        input  dig_in,
        input  code,
        output upd_ack,
        output num,
        output dig
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 8-digit seven-segment scan controller with frame-synchronous update
module seg_scan_ctrl #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_ctrl_if.slave      bus,
    input  logic                blank_lz,
    input  logic [7:0]          en_mask,
    output logic [7:0]          an,
    output logic [7:0]          seg
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] psc;
    logic [2:0]    num_q;
    logic [31:0]   dig_q;
    logic [31:0]   shadow;
    logic          pending;
    logic          ack_q;

    logic          tick;
    logic          frame_end;
    logic [7:0]    upper_zero;
    logic [7:0]    visible;
    logic [7:0]    seg_next;
    logic [7:0]    an_next;

    assign tick      = (psc == PSC_LAST);
    assign frame_end = tick && (num_q == 3'd7);

    assign bus.num     = num_q;
    assign bus.dig     = dig_q;
    assign bus.upd_ack = ack_q;

    // prescaler sets the digit slot length; wraps after CLK_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
        end else if (tick) begin
            psc <= '0;
        end else begin
            psc <= psc + 1'b1;
        end
    end

    // scan index steps once per slot, wrapping 7 -> 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q <= 3'd0;
        end else if (tick) begin
            num_q <= num_q + 3'd1;
        end
    end

    // shadow/pending capture and commit only at the frame boundary so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q   <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (frame_end && pending) begin
                dig_q <= shadow;
                ack_q <= 1'b1;
            end
            // an update landing on the commit edge refills the shadow and stays pending
            if (bus.upd) begin
                shadow  <= bus.dig_in;
                pending <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    // upper_zero[i]: nibbles i..7 of the displayed value are all zero
    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < 8; i++) begin
            upper_zero[i] = 1'b1;
            for (int j = i; j < 8; j++) begin
                if (dig_q[j*4 +: 4] != 4'h0) begin
                    upper_zero[i] = 1'b0;
                end
            end
        end
    end

    // digit visibility: enable mask, minus leading zeros when blanking; digit 0 always survives blanking
    always_comb begin
        visible = en_mask;
        for (int i = 1; i < 8; i++) begin
            if (blank_lz && upper_zero[i]) begin
                visible[i] = 1'b0;
            end
        end
    end

    // anode select: ghost-blank the cycle after a tick while seg catches up with the new num
    always_comb begin
        an_next = 8'hFF;
        if (!tick && visible[num_q]) begin
            an_next = ~(8'h01 << num_q);
        end
    end

    // hex to active-low segments {dp,g,f,e,d,c,b,a}; dp stays off
    always_comb begin
        seg_next = 8'hFF;
        case (bus.code)
            4'h0: seg_next = 8'hC0;
            4'h1: seg_next = 8'hF9;
            4'h2: seg_next = 8'hA4;
            4'h3: seg_next = 8'hB0;
            4'h4: seg_next = 8'h99;
            4'h5: seg_next = 8'h92;
            4'h6: seg_next = 8'h82;
            4'h7: seg_next = 8'hF8;
            4'h8: seg_next = 8'h80;
            4'h9: seg_next = 8'h90;
            4'hA: seg_next = 8'h88;
            4'hB: seg_next = 8'h83;
            4'hC: seg_next = 8'hC6;
            4'hD: seg_next = 8'hA1;
            4'hE: seg_next = 8'h86;
            4'hF: seg_next = 8'h8E;
            default: seg_next = 8'hFF;
        endcase
    end

    // register the drive outputs so anode and segment change on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam int FRAME = 8 * CLK_DIV;

    logic       clk;
    logic       rst_n;
    logic       blank_lz;
    logic [7:0] en_mask;
    logic [7:0] an;
    logic [7:0] seg;

    seg_scan_ctrl_if bus ();

    // external digit selector
    assign bus.code = bus.dig[bus.num*4 +: 4];

    seg_scan_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .blank_lz (blank_lz),
        .en_mask  (en_mask),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic        blz;
        logic [7:0]  mask;
        logic [7:0]  vis;
    } vec_t;

    vec_t vecs [8];

    logic [7:0] hex_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int          errors = 0;
    int          checks = 0;
    int          ack_cnt = 0;
    int          tear_bad = 0;
    logic        prev_ack = 1'b0;
    logic        last_ack = 1'b0;
    logic [31:0] cur_dig = 32'h0;
    logic [31:0] sb [$];

    task automatic check(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // advance one clock; sample at the falling edge and retire any commit against the scoreboard
    task automatic cycle();
        logic [31:0] exp;
        @(negedge clk);
        bus.upd = 1'b0;
        last_ack = bus.upd_ack;
        if (bus.upd_ack) begin
            ack_cnt++;
            check(!prev_ack, "ack_width", 32'(prev_ack), 32'h0);
            if (sb.size() == 0) begin
                check(1'b0, "spurious_ack", 32'h1, 32'h0);
            end else begin
                exp = sb.pop_front();
                check(bus.dig === exp, "commit_dig", bus.dig, exp);
                cur_dig = exp;
            end
        end else if (bus.dig !== cur_dig) begin
            tear_bad++;
        end
        prev_ack = bus.upd_ack;
    endtask

    task automatic drive_upd(input logic [31:0] value, input logic overwrite);
        bus.upd    = 1'b1;
        bus.dig_in = value;
        if (overwrite && sb.size() > 0) void'(sb.pop_back());
        sb.push_back(value);
    endtask

    task automatic wait_ack(input string name);
        logic got = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            cycle();
            if (last_ack) begin
                got = 1'b1;
                break;
            end
        end
        check(got, name, 32'(got), 32'h1);
    endtask

    task automatic wait_num(input logic [2:0] n);
        logic got = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle();
            if (bus.num == n) begin
                got = 1'b1;
                break;
            end
        end
        check(got, "wait_num", 32'(bus.num), 32'(n));
    endtask

    // one full frame starting right after a slot-0 ghost cycle
    task automatic observe_frame(input logic [31:0] d, input logic [7:0] vis, input string name);
        int an_bad = 0;
        int seg_bad = 0;
        int ghost_bad = 0;
        int slot;
        logic [7:0] exp_an;
        for (int k = 1; k <= FRAME; k++) begin
            cycle();
            if (k % CLK_DIV == 0) begin
                if (an !== 8'hFF) ghost_bad++;
            end else begin
                slot = k / CLK_DIV;
                exp_an = vis[slot] ? ~(8'h01 << slot) : 8'hFF;
                if (an !== exp_an) an_bad++;
                else if (vis[slot] && seg !== hex_ref[d[slot*4 +: 4]]) seg_bad++;
            end
        end
        check(an_bad == 0, {name, "_an"}, 32'(an_bad), 32'h0);
        check(seg_bad == 0, {name, "_seg"}, 32'(seg_bad), 32'h0);
        check(ghost_bad == 0, {name, "_ghost"}, 32'(ghost_bad), 32'h0);
    endtask

    task automatic check_reset(input string name);
        check(an === 8'hFF, {name, "_an"}, 32'(an), 32'hFF);
        check(seg === 8'hFF, {name, "_seg"}, 32'(seg), 32'hFF);
        check(bus.upd_ack === 1'b0, {name, "_ack"}, 32'(bus.upd_ack), 32'h0);
        check(bus.num === 3'd0, {name, "_num"}, 32'(bus.num), 32'h0);
        check(bus.dig === 32'h0, {name, "_dig"}, bus.dig, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks_before;

        vecs[0] = '{32'h76543210, 1'b0, 8'hFF, 8'hFF};
        vecs[1] = '{32'h89ABCDEF, 1'b0, 8'hFF, 8'hFF};
        vecs[2] = '{32'h000000A5, 1'b1, 8'hFF, 8'h03};
        vecs[3] = '{32'h00000000, 1'b1, 8'hFF, 8'h01};
        vecs[4] = '{32'h0F00F000, 1'b1, 8'hFF, 8'h7F};
        vecs[5] = '{32'h12345678, 1'b0, 8'hA5, 8'hA5};
        vecs[6] = '{32'h00100000, 1'b1, 8'h0F, 8'h0F};
        vecs[7] = '{32'h00000000, 1'b0, 8'h00, 8'h00};

        rst_n      = 1'b1;
        bus.upd    = 1'b0;
        bus.dig_in = 32'h0;
        blank_lz   = 1'b0;
        en_mask    = 8'hFF;
        #1 rst_n   = 1'b0;

        repeat (3) cycle();
        check_reset("reset");
        rst_n = 1'b1;
        observe_frame(32'h0, 8'hFF, "idle");

        // table: commit each value mid-frame, then verify the following frame
        for (int v = 0; v < 8; v++) begin
            blank_lz = vecs[v].blz;
            en_mask  = vecs[v].mask;
            wait_num(3'd2);
            drive_upd(vecs[v].value, 1'b0);
            wait_ack($sformatf("ack_vec%0d", v));
            observe_frame(vecs[v].value, vecs[v].vis, $sformatf("vec%0d", v));
        end

        // two updates before the boundary: last one wins, single acknowledge
        blank_lz = 1'b0;
        en_mask  = 8'hFF;
        wait_num(3'd2);
        acks_before = ack_cnt;
        drive_upd(32'h11111111, 1'b0);
        repeat (3) cycle();
        drive_upd(32'h22222222, 1'b1);
        wait_ack("ack_double");
        observe_frame(32'h22222222, 8'hFF, "double");
        check(ack_cnt - acks_before == 1, "double_ack_count", 32'(ack_cnt - acks_before), 32'h1);

        // update coinciding with the commit edge: old shadow commits, new one stays pending
        wait_num(3'd2);
        drive_upd(32'h33333333, 1'b0);
        wait_ack("ack_sync");
        repeat (10) cycle();
        drive_upd(32'h44444444, 1'b0);
        repeat (FRAME - 11) cycle();
        drive_upd(32'h55555555, 1'b0);
        wait_ack("ack_coinc_old");
        check(bus.dig === 32'h44444444, "coinc_old_dig", bus.dig, 32'h44444444);
        wait_ack("ack_coinc_new");
        check(bus.dig === 32'h55555555, "coinc_new_dig", bus.dig, 32'h55555555);

        // single enabled digit, then reset mid-frame with an update pending
        en_mask = 8'h01;
        wait_num(3'd2);
        drive_upd(32'h00000000, 1'b0);
        wait_ack("ack_zero");
        observe_frame(32'h0, 8'h01, "mask01");
        wait_num(3'd3);
        drive_upd(32'h66666666, 1'b0);
        repeat (2) cycle();
        rst_n = 1'b0;
        sb.delete();
        cur_dig = 32'h0;
        repeat (3) cycle();
        check_reset("midreset");
        acks_before = ack_cnt;
        rst_n = 1'b1;
        observe_frame(32'h0, 8'h01, "post_reset");
        repeat (2 * FRAME) cycle();
        check(ack_cnt == acks_before, "no_ack_after_reset", 32'(ack_cnt - acks_before), 32'h0);

        check(tear_bad == 0, "no_tear", 32'(tear_bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port upd  input  1: one-cycle strobe requesting display of dig_in.
REQ-005 SHALL have port dig_in  input  32: new value, eight 4-bit nibbles, nibble i = digit i.
REQ-006 SHALL have port blank_lz  input  1: 1 = blank leading-zero digits.
REQ-007 SHALL have port en_mask  input  8: bit i = 1 enables digit i.
REQ-008 SHALL have port num  output  3: current scan index, driven to the digit selector.
REQ-009 SHALL have port dig  output  32: displayed (committed) value, driven to the digit selector.
REQ-010 SHALL have port code  input  4: selected nibble returned by the digit selector (dig nibble num).
REQ-011 SHALL have port an  output  8: digit anodes, active-low, at most one bit low.
REQ-012 SHALL have port seg  output  8: segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1.
REQ-013 SHALL have port upd_ack  output  1: one-cycle pulse when a pending value is committed to dig.

Function
REQ-014 SHALL run a prescaler counting 0..CLK_DIV-1, wrapping to 0; tick = prescaler at CLK_DIV-1.
REQ-015 SHALL advance num by 1 on each tick, 7 wraps to 0; num unchanged otherwise.
REQ-016 SHALL, on upd=1, capture dig_in into a shadow register and set pending=1; a later upd before commit overwrites shadow (last value wins).
REQ-017 SHALL commit only at frame boundary: on the edge where tick=1 and num=7, if pending, dig <= shadow, pending <= 0, upd_ack <= 1 for one cycle.
REQ-018 SHALL, when upd=1 coincides with a commit edge, commit the old shadow and keep pending=1 with the new dig_in in shadow.
REQ-019 SHALL never change dig outside a commit edge (no mid-frame tearing).
REQ-020 SHALL register seg every cycle from code via hex decode: 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90,A 88,b 83,C C6,d A1,E 86,F 8E.
REQ-021 SHALL force an=FF for the cycle after each tick (ghost-blank cycle), covering the 1-cycle seg register latency.
REQ-022 SHALL otherwise drive an = ~(1<<num) when digit num is visible, else an=FF.
REQ-023 SHALL define digit i visible iff en_mask[i]=1 and not (blank_lz=1, i!=0, and nibbles i..7 of dig all zero).
REQ-024 SHALL keep digit 0 visible under blank_lz even when dig=0 (shows "0").
REQ-025 SHALL sample en_mask and blank_lz each cycle (no latching); changes take effect on the next an update.

Reset
REQ-026 SHALL, while rst_n=0, hold prescaler=0, num=0, dig=0, shadow=0, pending=0, an=FF, seg=FF, upd_ack=0.
REQ-027 SHALL discard any pending update on reset, including reset asserted mid-frame or on a commit edge.
REQ-028 SHALL after rst_n release start prescaler from 0; first tick after CLK_DIV cycles.

Verification (bench uses CLK_DIV=4)
REQ-029 Reset release, dig_in idle, en_mask=FF, blank_lz=0 -> an cycles FE,FD,...,7F (with FF blank cycle after each tick), seg=C0 throughout visible slots.
REQ-030 upd with dig_in=0x76543210 at num=2 -> dig stays 0 until tick at num=7, then dig=0x76543210, upd_ack one cycle; next frame digit 5 shows seg=92.
REQ-031 Two upd pulses (0x11111111 then 0x22222222) before boundary -> single commit of 0x22222222, single upd_ack.
REQ-032 upd 0x000000A5, blank_lz=1 -> digits 2..7 an never low; digit 1 seg=88, digit 0 seg=92.
REQ-033 en_mask=0x01, dig=0 -> only an=FE ever low, seg=C0; rst_n pulsed low mid-frame with upd pending -> outputs at reset values, no later upd_ack.
